xnur_pipe: RTL and testbench
============================

// Module: xnur_pipe
// PURPOSE
//   Parametrised successor of the single-bit registered XNOR cell. Takes WIDTH-bit
//   operand pairs a/b, clears every bit position where both operands are 1, and
//   applies a selectable bitwise op over a 2-stage valid/ready pipeline.
//   Sits between operand producers and a compare/consumer stage. Also reports a
//   whole-word equality flag.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=1)
//   CNT_W   16  width of match counter (used only with XNUR_MATCH_CNT_EN)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/mode valid this cycle
//   in_ready   out  1      stage 1 can accept; transfer = in_valid & in_ready
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   mode       in   2      op select, captured with the operands
//   out_valid  out  1      y/all_eq valid
//   out_ready  in   1      consumer accepts; transfer = out_valid & out_ready
//   y          out  WIDTH  registered result
//   all_eq     out  1      1 when held operands equal in every bit (after clear rule)
//   cnt_clr    in   1      synchronous clear of match_cnt
//   match_cnt  out  CNT_W  count of output transfers with all_eq=1
// BEHAVIOUR
//   - Reset (async, rst_n=0): s1_valid=0, s2_valid=0, hold_a=hold_b=0, mode reg=0,
//     y=0, all_eq=0, match_cnt=0. in_ready=1 once rst_n=1. A reset mid-transfer
//     discards all in-flight words.
//   - Stage 1 (on input transfer), per bit i: if a[i]&b[i] then hold_a[i]=0,
//     hold_b[i]=0 else hold_a[i]=a[i], hold_b[i]=b[i]; mode captured.
//   - Stage 2 (on s1->s2 advance): y <= op(hold_a,hold_b); all_eq <= &(hold_a~^hold_b).
//     mode 00 XNOR, 01 XOR, 10 hold_a pass, 11 NOR.
//   - Latency: 2 cycles from input transfer to out_valid when output is not stalled.
//   - Flow: s2_adv = s1_valid & (!s2_valid | out_ready);
//     in_ready = !s1_valid | s2_adv (combinational, no bubble). Throughput is
//     1 word/cycle.
//   - Stall: out_valid=1 & out_ready=0 holds y/all_eq stable; back-pressure fills
//     s1, then drops in_ready. No word is ever dropped or duplicated.
//   - Simultaneous in transfer and s2_adv in the same cycle: both happen; s1 is
//     reloaded with the new word.
//   - Values on a/b/mode are ignored when in_valid=0.
// CONFIGURATION
//   XNUR_MATCH_CNT_EN defined: match_cnt increments on each output transfer
//     with all_eq=1.
//     - Saturates at 2^CNT_W-1.
//     - cnt_clr sets match_cnt to 0 next cycle and takes priority over an
//       increment in the same cycle.
//   Not defined: match_cnt tied to 0; cnt_clr ignored; no counter flops.
//     Ports are unchanged.
// STRUCTURE
//   Package xnur_pkg:
//     - typedef enum logic [1:0] xnur_mode_e {XNUR_XNOR, XNUR_XOR, XNUR_PASS_A, XNUR_NOR}
//     - function xnur_op(mode, a, b) for reuse by the bench model
//   Sub-module xnur_pipe_slice: generic valid/ready register slice, parameter
//     PAYLOAD_W, async active-low reset.
//     - Instantiated twice: payload 2*WIDTH+2 for stage 1, WIDTH+1 for stage 2.
// TESTING
//   1 Reset: rst_n=0 mid-stream -> out_valid=0, y=0, all_eq=0, match_cnt=0
//     immediately (async).
//   2 WIDTH=8, mode=XNOR, a=8'hF0, b=8'h3C, out_ready=1 -> 2 cycles later y=8'h33,
//     all_eq=0.
//   3 a=b=8'hFF, mode=XOR -> all bits cleared, y=8'h00, all_eq=1 (clear rule
//     then compare).
//   4 Back-to-back 4 words, out_ready low 3 cycles after the first output ->
//     in_ready=0 after 2 accepts, y held stable, all 4 words emitted in order
//     with none lost.
//   5 With XNUR_MATCH_CNT_EN and CNT_W=2: 5 equal words -> match_cnt saturates
//     at 3. Then cnt_clr together with a matching transfer -> match_cnt=0.
//   6 Without XNUR_MATCH_CNT_EN: same stimulus as 5 -> match_cnt stays 0.

Source files
------------

// File: rtl/xnur_pkg.sv
// Shared types and the per-bit operator for the xnur_pipe block.
// Imported by the RTL; the operator is bit-granular so any WIDTH can reuse it.
package xnur_pkg;

    typedef enum logic [1:0] {
        XNUR_XNOR   = 2'b00,
        XNUR_XOR    = 2'b01,
        XNUR_PASS_A = 2'b10,
        XNUR_NOR    = 2'b11
    } xnur_mode_e;

    localparam int XNUR_MODE_W = 2;

    function automatic logic xnur_op(input xnur_mode_e mode, input logic a, input logic b);
        logic r;
        case (mode)
            XNUR_XNOR:   r = ~(a ^ b);
            XNUR_XOR:    r = a ^ b;
            XNUR_PASS_A: r = a;
            XNUR_NOR:    r = ~(a | b);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xnur_pipe_if.sv
// Operand/result bus of xnur_pipe: input and output valid/ready channels plus
// the match counter side-band. master = producer/consumer side, slave = the pipe.
interface xnur_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    // Both channels: a word moves on a rising clk edge where valid & ready are 1;
    // the source keeps valid and its data stable until that edge, and ready may
    // depend combinationally on the downstream ready.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             all_eq;
    logic             cnt_clr;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output in_valid, a, b, mode, out_ready, cnt_clr,
        input  in_ready, out_valid, y, all_eq, match_cnt
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready, cnt_clr,
        output in_ready, out_valid, y, all_eq, match_cnt
    );
endinterface

// File: rtl/xnur_pipe_slice.sv
// Generic one-entry valid/ready register slice with full throughput:
// it accepts a new word in the same cycle its held word is taken downstream.
module xnur_pipe_slice #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PAYLOAD_W-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [PAYLOAD_W-1:0] o_data
);
    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/xnur_pipe.sv
// Two-stage registered XNOR/XOR/PASS/NOR pipe with whole-word equality flag.
// Optional saturating match counter enabled by defining XNUR_MATCH_CNT_EN.
module xnur_pipe
    import xnur_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    xnur_pipe_if.slave  bus
);
    localparam int S1_W = 2 * WIDTH + XNUR_MODE_W;
    localparam int S2_W = WIDTH + 1;

    logic [WIDTH-1:0] w_both;
    logic [S1_W-1:0]  w_s1_in;
    logic [S1_W-1:0]  w_s1_data;
    logic             w_s1_valid;
    logic             w_s2_ready;
    logic [WIDTH-1:0] w_hold_a;
    logic [WIDTH-1:0] w_hold_b;
    logic [1:0]       w_mode;
    logic [WIDTH-1:0] w_y_d;
    logic             w_eq_d;

    // Positions where both operands are 1 are cleared before anything else.
    assign w_both  = bus.a & bus.b;
    assign w_s1_in = {bus.mode, bus.a & ~w_both, bus.b & ~w_both};

    xnur_pipe_slice #(.PAYLOAD_W(S1_W)) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_data)
    );

    assign {w_mode, w_hold_a, w_hold_b} = w_s1_data;

    for (genvar i = 0; i < WIDTH; i++) begin : g_op
        assign w_y_d[i] = xnur_op(xnur_mode_e'(w_mode), w_hold_a[i], w_hold_b[i]);
    end

    assign w_eq_d = &(w_hold_a ~^ w_hold_b);

    xnur_pipe_slice #(.PAYLOAD_W(S2_W)) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_eq_d, w_y_d}),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready),
        .o_data  ({bus.all_eq, bus.y})
    );

`ifdef XNUR_MATCH_CNT_EN
    logic [CNT_W-1:0] r_match_cnt;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_match_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.all_eq && (r_match_cnt != '1)) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = r_match_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt    = '0;
`endif
endmodule

// File: tb/tb_xnur_pipe.sv
// Self-checking bench for xnur_pipe: directed scenarios plus randomized traffic
// against a word-level reference model and an expected-output queue.
module tb_xnur_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_in     = 0;
    int n_out    = 0;

    logic [WIDTH:0]   exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [WIDTH:0]   mon_e;
    logic             rnd_done;

    always #5 clk = ~clk;

    xnur_pipe_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    xnur_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Word-level reference: after clearing common 1s, the held operands differ
    // exactly where a^b is set, and held A is a with b's 1s removed.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [1:0] m);
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] y;
        diff = a ^ b;
        case (m)
            2'd0:    y = ~diff;
            2'd1:    y = diff;
            2'd2:    y = a & ~b;
            default: y = ~diff;
        endcase
        return {(a == b), y};
    endfunction

    // Scoreboard monitor: sampled on the falling edge, predicting the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (bus.match_cnt !== exp_cnt) begin
                n_fail++;
                $display("FAIL match_cnt: got %0d expected %0d at %0t", bus.match_cnt, exp_cnt, $time);
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h with empty queue at %0t", {bus.all_eq, bus.y}, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    n_out++;
                    if ({bus.all_eq, bus.y} !== mon_e) begin
                        n_fail++;
                        $display("FAIL output_word: got %h expected %h at %0t", {bus.all_eq, bus.y}, mon_e, $time);
                    end
`ifdef XNUR_MATCH_CNT_EN
                    if (!bus.cnt_clr && mon_e[WIDTH] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
`endif
                end
            end
`ifdef XNUR_MATCH_CNT_EN
            if (bus.cnt_clr) exp_cnt = '0;
`endif
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.mode));
                n_in++;
            end
        end else begin
            exp_cnt = '0;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] m);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.mode = m;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: queue size got %0d expected 0", exp_q.size());
        end
        sync();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.mode = 2'd0;
        bus.out_ready = 1'b0;
        bus.cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.all_eq, bus.y, bus.match_cnt, bus.in_ready} !== {1'b0, 1'b0, 8'h00, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b eq=%b y=%h cnt=%0d ir=%b expected 0 0 00 0 1",
                     bus.out_valid, bus.all_eq, bus.y, bus.match_cnt, bus.in_ready);
        end
        sync();
        // Stall a nonzero word at the output, then reset mid-cycle.
        send(8'h0F, 8'h00, 2'd1);
        sync();
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.y} !== {1'b1, 8'h0F}) begin
            n_fail++;
            $display("FAIL reset_prefill: got ov=%b y=%h expected 1 0f", bus.out_valid, bus.y);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.all_eq, bus.y, bus.match_cnt} !== {1'b0, 1'b0, 8'h00, 2'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got ov=%b eq=%b y=%h cnt=%0d expected 0 0 00 0",
                     bus.out_valid, bus.all_eq, bus.y, bus.match_cnt);
        end
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        sync();
    endtask

    task automatic test_basic();
        bus.in_valid = 1'b1;
        bus.a = 8'hF0;
        bus.b = 8'h3C;
        bus.mode = 2'd0;
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_c0: got ir=%b ov=%b expected 1 0", bus.in_ready, bus.out_valid);
        end
        sync();
        bus.in_valid = 1'b0;
        bus.a = 8'hAA;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_c1: out_valid got %b expected 0", bus.out_valid);
        end
        sync();
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.all_eq, bus.y} !== {1'b1, 1'b0, 8'h33}) begin
            n_fail++;
            $display("FAIL basic_c2: got ov=%b eq=%b y=%h expected 1 0 33", bus.out_valid, bus.all_eq, bus.y);
        end
        sync();
    endtask

    task automatic test_clear_rule();
        send(8'hFF, 8'hFF, 2'd1);
        sync();
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.all_eq, bus.y} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL clear_rule: got ov=%b eq=%b y=%h expected 1 1 00", bus.out_valid, bus.all_eq, bus.y);
        end
        sync();
        send(8'hAA, 8'hAA, 2'd3);
        send(8'hC3, 8'h81, 2'd2);
        drain();
    endtask

    task automatic test_back_to_back();
        int in0;
        int out0;
        logic [WIDTH-1:0] y0;
        in0 = n_in;
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)));
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                @(negedge clk);
                y0 = bus.y;
                n_checks++;
                if ({bus.out_valid, bus.in_ready, bus.all_eq, bus.y} !== {1'b1, 1'b0, exp_q[0]} || n_in - in0 != 2) begin
                    n_fail++;
                    $display("FAIL stall_start: got ov=%b ir=%b word=%h accepts=%0d expected 1 0 %h 2",
                             bus.out_valid, bus.in_ready, {bus.all_eq, bus.y}, n_in - in0, exp_q[0]);
                end
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    n_checks++;
                    if ({bus.out_valid, bus.in_ready, bus.y} !== {1'b1, 1'b0, y0}) begin
                        n_fail++;
                        $display("FAIL stall_hold: got ov=%b ir=%b y=%h expected 1 0 %h",
                                 bus.out_valid, bus.in_ready, bus.y, y0);
                    end
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (n_out - out0 != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs expected 4", n_out - out0);
        end
    endtask

    task automatic test_random();
        int out0;
        logic [WIDTH-1:0] ra;
        out0 = n_out;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        bus.a = WIDTH'($urandom);
                        bus.b = WIDTH'($urandom);
                        bus.mode = 2'($urandom_range(0, 3));
                        sync();
                    end
                    ra = WIDTH'($urandom);
                    send(ra, ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom), 2'($urandom_range(0, 3)));
                end
                rnd_done = 1'b1;
            end
            begin
                for (int c = 0; c < 2000 && !rnd_done; c++) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    sync();
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        n_checks++;
        if (n_out - out0 != 60) begin
            n_fail++;
            $display("FAIL random_count: got %0d outputs expected 60", n_out - out0);
        end
    endtask

    task automatic test_match_cnt();
        logic [CNT_W-1:0] sat_exp;
        logic [WIDTH-1:0] v;
`ifdef XNUR_MATCH_CNT_EN
        sat_exp = 2'd3;
`else
        sat_exp = 2'd0;
`endif
        bus.cnt_clr = 1'b1;
        sync();
        bus.cnt_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.match_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_initial_clear: got %0d expected 0", bus.match_cnt);
        end
        sync();
        for (int i = 0; i < 5; i++) begin
            v = WIDTH'($urandom);
            send(v, v, 2'($urandom_range(0, 3)));
        end
        drain();
        sync();
        @(negedge clk);
        n_checks++;
        if (bus.match_cnt !== sat_exp) begin
            n_fail++;
            $display("FAIL cnt_saturate: got %0d expected %0d", bus.match_cnt, sat_exp);
        end
        sync();
        send(8'h5A, 8'h5A, 2'd0);
        sync();
        bus.cnt_clr = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.out_ready, bus.all_eq} !== 3'b111) begin
            n_fail++;
            $display("FAIL cnt_clr_setup: got ov=%b or=%b eq=%b expected 1 1 1", bus.out_valid, bus.out_ready, bus.all_eq);
        end
        sync();
        bus.cnt_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.match_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL cnt_clr_priority: got %0d expected 0", bus.match_cnt);
        end
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_clear_rule();
        test_back_to_back();
        test_random();
        test_match_cnt();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
